// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the
// oversampling tick divider used by both the TX and RX sides.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int tick_div(input int clock_rate,
                                    input int baud_rate,
                                    input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock o_Tick every DIV clocks.
// Ports: clk, reset (sync, high), i_Restart (realign phase), o_Tick.
module uart_baud_tick #(
    parameter int DIV = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Restart,
    output logic o_Tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || i_Restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // A restart wins so the first tick of a frame is a full period away.
    assign o_Tick = (cnt == LAST) && !i_Restart;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver, oversampled with 3-sample majority per bit.
// Ports: clk, reset (sync, high), i_Rx_Data (async line), o_Rx_Byte,
// o_Rx_Done (1-clk strobe), o_Rx_Active, o_Rx_Frame_Err (1-clk strobe).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 115200,
    parameter int RX_OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_Rx_Data,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Done,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam int TICK_DIV = tick_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);
    localparam int SW = $clog2(RX_OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);

    localparam logic [SW-1:0] S_A    = SW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(RX_OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C    = SW'(RX_OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(RX_OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_BITS - 1);

    rx_state_t state, state_d;

    logic rx_m, rx_s, rx_q;
    logic tick;
    logic [SW-1:0] s_cnt;
    logic [BW-1:0] bit_cnt;
    logic smp_a, smp_b;
    logic maj, decide;
    logic [UART_DATA_BITS-1:0] shift_reg;

    logic start_frame, shift_en, load_byte, frame_err, active_d;

    // Two-flop synchroniser plus one flop of history for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= i_Rx_Data;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    uart_baud_tick #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .i_Restart(start_frame),
        .o_Tick   (tick)
    );

    // Third sample is the live line value at the decision tick.
    assign maj    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign decide = tick && (s_cnt == S_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            s_cnt <= '0;
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            if (start_frame || state == ST_IDLE || state == ST_BREAK)
                s_cnt <= '0;
            else if (tick)
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
            if (tick && s_cnt == S_A)
                smp_a <= rx_s;
            if (tick && s_cnt == S_B)
                smp_b <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d     = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        load_byte   = 1'b0;
        frame_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_q && !rx_s) begin
                    start_frame = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (decide)
                    state_d = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_cnt == B_LAST)
                        state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (maj) begin
                        load_byte = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        active_d = (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt        <= '0;
            shift_reg      <= '0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Done      <= 1'b0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            if (start_frame)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)
                shift_reg <= {maj, shift_reg[UART_DATA_BITS-1:1]};
            if (load_byte)
                o_Rx_Byte <= shift_reg;
            o_Rx_Done      <= load_byte;
            o_Rx_Frame_Err <= frame_err;
            o_Rx_Active    <= active_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed and randomized
// frames checked against a queue of expected bytes.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Done;
    logic       o_Rx_Active;
    logic       o_Rx_Frame_Err;

    always #5 clk = ~clk;

    uart_rx_sampler dut (
        .clk           (clk),
        .reset         (reset),
        .i_Rx_Data     (rx),
        .o_Rx_Byte     (o_Rx_Byte),
        .o_Rx_Done     (o_Rx_Done),
        .o_Rx_Active   (o_Rx_Active),
        .o_Rx_Frame_Err(o_Rx_Frame_Err)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int exp_done = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    bit active_seen = 1'b0;
    bit done_prev = 1'b0;
    logic [7:0] t2 [8] = '{8'h01, 8'h10, 8'h22, 8'h32,
                           8'h55, 8'hAA, 8'hAB, 8'h88};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame: start 0, 8 data bits LSB first, one stop bit.
    task automatic send(input logic [7:0] b, input int per,
                        input logic stop_v);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        if (stop_v) begin
            exp_q.push_back(b);
            exp_done++;
        end
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            wait_clks(per);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (o_Rx_Active)
                active_seen = 1'b1;
            if (o_Rx_Done) begin
                done_cnt++;
                chk("done_single", {31'd0, done_prev}, 0);
                chk("done_err_excl", {31'd0, o_Rx_Frame_Err}, 0);
                chk("active_at_done", {31'd0, o_Rx_Active}, 0);
                chk("done_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_byte", {24'd0, o_Rx_Byte}, {24'd0, e});
                    last_good = e;
                end
            end
            if (o_Rx_Frame_Err) begin
                err_cnt++;
                chk("err_byte_held", {24'd0, o_Rx_Byte}, {24'd0, last_good});
                chk("active_at_err", {31'd0, o_Rx_Active}, 0);
            end
            done_prev = o_Rx_Done;
        end
    endtask

    initial begin
        logic [7:0] b;
        int per;
        fork
            monitor();
        join_none

        // Reset state
        wait_clks(3);
        chk("rst_byte", {24'd0, o_Rx_Byte}, 0);
        chk("rst_done", {31'd0, o_Rx_Done}, 0);
        chk("rst_active", {31'd0, o_Rx_Active}, 0);
        chk("rst_err", {31'd0, o_Rx_Frame_Err}, 0);
        reset = 1'b0;
        wait_clks(20);

        // Single nominal frame
        send(8'h55, 208, 1'b1);
        wait_clks(100);
        chk("t1_done_cnt", done_cnt, exp_done);
        chk("t1_byte", {24'd0, o_Rx_Byte}, 32'h55);
        chk("t1_err_cnt", err_cnt, 0);

        // Back-to-back frames from a slow transmitter
        for (int i = 0; i < 8; i++)
            send(t2[i], 217, 1'b1);
        wait_clks(100);
        chk("t2_done_cnt", done_cnt, exp_done);
        chk("t2_pending", exp_q.size(), 0);
        chk("t2_byte", {24'd0, o_Rx_Byte}, 32'h88);

        // Start-bit glitches
        active_seen = 1'b0;
        rx = 1'b0;
        wait_clks(1);
        rx = 1'b1;
        wait_clks(400);
        rx = 1'b0;
        wait_clks(5);
        rx = 1'b1;
        wait_clks(400);
        chk("t3_active_seen", {31'd0, active_seen}, 0);
        chk("t3_done_cnt", done_cnt, exp_done);
        chk("t3_err_cnt", err_cnt, 0);

        // Framing error, held break, then recovery
        send(8'hA0, 208, 1'b0);
        wait_clks(20 * 208);
        rx = 1'b1;
        wait_clks(2 * 208);
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_byte_held", {24'd0, o_Rx_Byte}, 32'h88);
        chk("t4_done_cnt", done_cnt, exp_done);
        send(8'h0B, 208, 1'b1);
        wait_clks(100);
        chk("t4_recover_byte", {24'd0, o_Rx_Byte}, 32'h0B);
        chk("t4_recover_cnt", done_cnt, exp_done);

        // Reset in the middle of a frame of 8'hFF
        rx = 1'b0;
        wait_clks(208);
        rx = 1'b1;
        wait_clks(4 * 208 + 50);
        chk("t5_active_pre", {31'd0, o_Rx_Active}, 1);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        last_good = 8'h00;
        chk("t5_byte", {24'd0, o_Rx_Byte}, 0);
        chk("t5_done", {31'd0, o_Rx_Done}, 0);
        chk("t5_active", {31'd0, o_Rx_Active}, 0);
        chk("t5_err", {31'd0, o_Rx_Frame_Err}, 0);
        wait_clks(5 * 208);
        chk("t5_no_done", done_cnt, exp_done);
        send(8'h21, 208, 1'b1);
        wait_clks(100);
        chk("t5_next_byte", {24'd0, o_Rx_Byte}, 32'h21);

        // One-clock spike inside data bit 3 of 8'h00
        exp_q.push_back(8'h00);
        exp_done++;
        rx = 1'b0;
        wait_clks(4 * 208 + 117);
        rx = 1'b1;
        wait_clks(1);
        rx = 1'b0;
        wait_clks(9 * 208 - (4 * 208 + 118));
        rx = 1'b1;
        wait_clks(208 + 100);
        chk("t6_byte", {24'd0, o_Rx_Byte}, 0);
        chk("t6_done_cnt", done_cnt, exp_done);

        // Random bytes at random rates within tolerance
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            per = int'($urandom_range(204, 216));
            send(b, per, 1'b1);
            wait_clks(int'($urandom_range(20, 60)));
        end
        wait_clks(300);
        chk("t7_pending", exp_q.size(), 0);
        chk("t7_done_cnt", done_cnt, exp_done);
        chk("t7_err_cnt", err_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
